s386_bist_ctrl: RTL

//  Built-in self-test sequencer for the s386 benchmark core. It holds the core in reset, then applies
//  a run of pseudo-random 7-bit input vectors from an LFSR and compacts the core's 7-bit output into a

---
 rtl/s386_bist_pkg.sv | 19 +
 rtl/s386_bist_lfsr_misr.sv | 63 ++++++
 rtl/s386_bist_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/s386_bist_pkg.sv
// Shared definitions for the s386 BIST sequencer: FSM encoding, shift-register taps
// and the seed used whenever a zero seed is requested.
package s386_bist_pkg;

    localparam int S386_VEC_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    // x^7 + x^6 + 1: feedback from bits 6 and 5, maximal length 127
    localparam logic [S386_VEC_W-1:0] LFSR_TAPS    = 7'h60;
    localparam logic [S386_VEC_W-1:0] MISR_TAPS    = 7'h60;
    localparam logic [S386_VEC_W-1:0] DEFAULT_SEED = 7'h01;

endpackage

// File: rtl/s386_bist_lfsr_misr.sv
// Pattern generator (LFSR) and output compactor (MISR) sharing one shift/feedback form.
// Next-state values are exported so the controller can register outputs in step.
module s386_bist_lfsr_misr
    import s386_bist_pkg::*;
#(
    parameter int               VEC_W      = S386_VEC_W,
    parameter logic [VEC_W-1:0] GEN_TAPS   = LFSR_TAPS,
    parameter logic [VEC_W-1:0] CMP_TAPS   = MISR_TAPS,
    parameter logic [VEC_W-1:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [VEC_W-1:0] seed_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [VEC_W-1:0] data_i,
    output logic [VEC_W-1:0] lfsr_o,
    output logic [VEC_W-1:0] misr_o,
    output logic [VEC_W-1:0] lfsr_nxt_o,
    output logic [VEC_W-1:0] misr_nxt_o
);

    logic [VEC_W-1:0] lfsr_q, lfsr_d;
    logic [VEC_W-1:0] misr_q, misr_d;

    function automatic logic [VEC_W-1:0] shift_fb(input logic [VEC_W-1:0] q,
                                                  input logic [VEC_W-1:0] taps);
        return {q[VEC_W-2:0], ^(q & taps)};
    endfunction

    assign lfsr_nxt_o = shift_fb(lfsr_q, GEN_TAPS);
    assign misr_nxt_o = shift_fb(misr_q, CMP_TAPS) ^ data_i;

    always_comb begin
        lfsr_d = lfsr_q;
        misr_d = misr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (en_i) begin
            lfsr_d = lfsr_nxt_o;
        end
        if (clear_i) begin
            misr_d = '0;
        end else if (en_i) begin
            misr_d = misr_nxt_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= RESET_SEED;
            misr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            misr_q <= misr_d;
        end
    end

    assign lfsr_o = lfsr_q;
    assign misr_o = misr_q;

endmodule

// File: rtl/s386_bist_ctrl.sv
// BIST sequencer for the s386 core: holds the core in reset, streams LFSR vectors into it,
// compacts its outputs into a MISR signature and reports it through a start/done handshake.
module s386_bist_ctrl
    import s386_bist_pkg::*;
#(
    parameter int VEC_W   = S386_VEC_W,
    parameter int CNT_W   = 16,
    parameter int RST_CYC = 2
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [VEC_W-1:0] seed,
    output logic             busy,
    output logic             done,
    output logic [VEC_W-1:0] signature,
    output logic             dut_reset,
    output logic [VEC_W-1:0] dut_in,
    input  logic [VEC_W-1:0] dut_out
);

    localparam int               RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYC - 1);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] nv_q, nv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dut_reset_q, dut_reset_d;
    logic [VEC_W-1:0] dut_in_q, dut_in_d;
    logic [VEC_W-1:0] sig_q, sig_d;

    logic             accept;
    logic             gen_en;
    logic [VEC_W-1:0] seed_eff;
    logic [VEC_W-1:0] lfsr_cur, lfsr_nxt;
    logic [VEC_W-1:0] misr_cur, misr_nxt;

    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
    assign gen_en   = (state_q == ST_RUN);

    s386_bist_lfsr_misr #(
        .VEC_W      (VEC_W),
        .GEN_TAPS   (LFSR_TAPS),
        .CMP_TAPS   (MISR_TAPS),
        .RESET_SEED (DEFAULT_SEED)
    ) u_shift (
        .clk_i      (blif_clk_net),
        .rst_i      (blif_reset_net),
        .load_i     (accept),
        .seed_i     (seed_eff),
        .clear_i    (accept),
        .en_i       (gen_en),
        .data_i     (dut_out),
        .lfsr_o     (lfsr_cur),
        .misr_o     (misr_cur),
        .lfsr_nxt_o (lfsr_nxt),
        .misr_nxt_o (misr_nxt)
    );

    always_comb begin
        state_d = state_q;
        nv_d    = nv_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        accept  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        accept  = 1'b1;
                        nv_d    = num_vectors;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                        state_d = ST_CLR;
                    end
                end
                ST_CLR: begin
                    rcnt_d = rcnt_q + RC_W'(1);
                    if (rcnt_q == RC_LAST) begin
                        state_d = (nv_q == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == nv_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    // The vector on dut_in always equals lfsr_q while in RUN.
    always_comb begin
        busy_d      = (state_d == ST_CLR) || (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        dut_reset_d = (state_d != ST_RUN);
        dut_in_d    = '0;
        sig_d       = sig_q;
        if (state_d == ST_RUN) begin
            dut_in_d = (state_q == ST_RUN) ? lfsr_nxt : lfsr_cur;
        end
        if (state_d == ST_DONE) begin
            sig_d = (state_q == ST_RUN) ? misr_nxt : misr_cur;
        end
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q     <= ST_IDLE;
            nv_q        <= '0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dut_reset_q <= 1'b1;
            dut_in_q    <= '0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            nv_q        <= nv_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dut_reset_q <= dut_reset_d;
            dut_in_q    <= dut_in_d;
            sig_q       <= sig_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dut_reset = dut_reset_q;
    assign dut_in    = dut_in_q;
    assign signature = sig_q;

endmodule
